// File: rtl/mealy_seq_detector_pkg.sv
// Shared types and elaboration-time helpers for the Mealy pattern detector.
// The next-state table is the KMP transition function derived from PATTERN.
package mealy_seq_detector_pkg;

  localparam int MAX_PAT_W = 16;
  localparam int ENT_W     = 5;
  localparam logic IDLE_FLAG = 1'b1;

  typedef logic [ENT_W-1:0] nxt_t;
  typedef nxt_t nxt_tbl_t [0:2*MAX_PAT_W-1];

  function automatic int state_w(input int pat_w);
    return $clog2(pat_w + 1) + 1;
  endfunction

  // Bit i of the result is the i-th pattern bit received (index 0 arrives first).
  function automatic logic [MAX_PAT_W-1:0] pat_rev(input logic [MAX_PAT_W-1:0] pat,
                                                   input int pat_w);
    logic [MAX_PAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < pat_w; i++) r[i] = pat[pat_w-1-i];
    return r;
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, then b),
  // capped below the full pattern length so a full match yields the failure length.
  function automatic int kmp_next(input logic [MAX_PAT_W-1:0] pat, input int pat_w,
                                  input int k, input logic b);
    logic [MAX_PAT_W-1:0] pr;
    int best;
    int lmax;
    int s;
    logic ok;
    logic sb;
    pr   = pat_rev(pat, pat_w);
    best = 0;
    lmax = (k + 1 < pat_w) ? k + 1 : pat_w - 1;
    for (int l = 1; l <= lmax; l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        s  = k + 1 - l + i;
        sb = (s < k) ? pr[s] : b;
        if (sb != pr[i]) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

  function automatic nxt_tbl_t build_next_table(input logic [MAX_PAT_W-1:0] pat,
                                                input int pat_w);
    nxt_tbl_t t;
    for (int i = 0; i < 2*MAX_PAT_W; i++) t[i] = '0;
    for (int k = 0; k < pat_w; k++) begin
      t[2*k]   = nxt_t'(kmp_next(pat, pat_w, k, 1'b0));
      t[2*k+1] = nxt_t'(kmp_next(pat, pat_w, k, 1'b1));
    end
    return t;
  endfunction

  function automatic int fail_len(input logic [MAX_PAT_W-1:0] pat, input int pat_w);
    logic [MAX_PAT_W-1:0] pr;
    pr = pat_rev(pat, pat_w);
    return kmp_next(pat, pat_w, pat_w - 1, pr[pat_w-1]);
  endfunction

endpackage

// File: rtl/mealy_seq_detector_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy serial pattern detector with registered match pulse,
// run-time overlap select and saturating match count.
module mealy_seq_detector
  import mealy_seq_detector_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din_valid,
  input  logic                       din,
  input  logic                       overlap,
  input  logic                       clr_cnt,
  output logic                       dout,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [$clog2(PAT_W+1)-1:0] prefix_len
);

  localparam int PW = $clog2(PAT_W + 1);
  localparam int SW = state_w(PAT_W);
  localparam logic [MAX_PAT_W-1:0] PAT_EXT  = MAX_PAT_W'(PATTERN);
  localparam logic [MAX_PAT_W-1:0] PAT_REV  = pat_rev(PAT_EXT, PAT_W);
  localparam nxt_tbl_t             NXT_TBL  = build_next_table(PAT_EXT, PAT_W);
  localparam int                   FAIL_LEN = fail_len(PAT_EXT, PAT_W);

  // State: MSB flags IDLE, low PW bits hold the matched-prefix length k.
  logic [SW-1:0] r_state;
  logic          r_dout;
  logic [SW-1:0] w_state_nxt;
  logic          w_match;
  logic          w_idle;
  logic [PW-1:0] w_k;
  logic [3:0]    w_k4;

  assign w_idle = r_state[SW-1];
  assign w_k    = r_state[PW-1:0];
  assign w_k4   = 4'(w_k);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= {IDLE_FLAG, PW'(0)};
      r_dout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dout  <= w_match;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_idle) begin
      w_state_nxt = '0;
    end else if (din_valid) begin
      if (w_match) begin
        w_state_nxt = overlap ? {1'b0, PW'(FAIL_LEN)} : '0;
      end else begin
        w_state_nxt = {1'b0, NXT_TBL[{w_k4, din}][PW-1:0]};
      end
    end
  end

  always_comb begin
    w_match = 1'b0;
    if (!w_idle && din_valid && (din == PAT_REV[w_k4]) && (w_k == PW'(PAT_W - 1))) begin
      w_match = 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (w_match),
    .cnt (match_cnt)
  );

  assign dout       = r_dout;
  assign prefix_len = w_k;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Directed bench: DUT A uses PATTERN=1011 with a 2-bit counter, DUT B uses 111
// for the back-to-back overlap case. Both share the input stimulus.
module tb_mealy_seq_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_valid = 1'b0;
  logic din = 1'b0;
  logic overlap = 1'b1;
  logic clr_cnt = 1'b0;

  logic       a_dout;
  logic [1:0] a_cnt;
  logic [2:0] a_pref;
  logic       b_dout;
  logic [7:0] b_cnt;
  logic [1:0] b_pref;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) u_a (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .overlap(overlap),
    .clr_cnt(clr_cnt), .dout(a_dout), .match_cnt(a_cnt), .prefix_len(a_pref)
  );

  mealy_seq_detector #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .overlap(overlap),
    .clr_cnt(clr_cnt), .dout(b_dout), .match_cnt(b_cnt), .prefix_len(b_pref)
  );

  task automatic step(input logic v, input logic d);
    din_valid = v;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  // Reset for two cycles, release, and burn the IDLE cycle with a '1' that must be ignored.
  task automatic idle_start();
    rst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
    step(1'b1, 1'b1);
  endtask

  task automatic test_reset();
    logic [3:0] bits;
    bits = 4'b1011;
    rst = 1'b1; overlap = 1'b1; clr_cnt = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_vec++;
    if ({a_dout, a_cnt, a_pref, b_pref} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_state: got dout=%b cnt=%0d pref=%0d bpref=%0d want all 0",
               a_dout, a_cnt, a_pref, b_pref);
    end
    rst = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, bits[i]);
      n_vec++;
      if (a_dout !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle_dout bit %0d: got %b want 0", 3 - i, a_dout);
      end
    end
    n_vec++;
    if (a_cnt !== 2'd0 || a_pref !== 3'd1) begin
      n_err++;
      $display("FAIL reset_idle_end: got cnt=%0d pref=%0d want cnt=0 pref=1", a_cnt, a_pref);
    end
  endtask

  task automatic test_overlap_on();
    logic [6:0] bits;
    logic [6:0] exp;
    bits = 7'b1011011;
    exp  = 7'b0001001;
    overlap = 1'b1;
    idle_start();
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, bits[i]);
      n_vec++;
      if (a_dout !== exp[i]) begin
        n_err++;
        $display("FAIL overlap_on_dout bit %0d: got %b want %b", 7 - i, a_dout, exp[i]);
      end
    end
    n_vec++;
    if (a_cnt !== 2'd2) begin
      n_err++;
      $display("FAIL overlap_on_cnt: got %0d want 2", a_cnt);
    end
  endtask

  task automatic test_overlap_off();
    logic [6:0] bits;
    logic [6:0] exp;
    bits = 7'b1011011;
    exp  = 7'b0001000;
    overlap = 1'b0;
    idle_start();
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, bits[i]);
      n_vec++;
      if (a_dout !== exp[i]) begin
        n_err++;
        $display("FAIL overlap_off_dout bit %0d: got %b want %b", 7 - i, a_dout, exp[i]);
      end
    end
    n_vec++;
    if (a_cnt !== 2'd1 || a_pref !== 3'd1) begin
      n_err++;
      $display("FAIL overlap_off_end: got cnt=%0d pref=%0d want cnt=1 pref=1", a_cnt, a_pref);
    end
  endtask

  task automatic test_valid_gaps();
    overlap = 1'b1;
    idle_start();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b1);
      n_vec++;
      if (a_pref !== 3'd2 || a_dout !== 1'b0) begin
        n_err++;
        $display("FAIL gap_hold cycle %0d: got pref=%0d dout=%b want pref=2 dout=0",
                 g, a_pref, a_dout);
      end
    end
    step(1'b1, 1'b1);
    n_vec++;
    if (a_dout !== 1'b0 || a_pref !== 3'd3) begin
      n_err++;
      $display("FAIL gap_resume: got dout=%b pref=%0d want dout=0 pref=3", a_dout, a_pref);
    end
    step(1'b1, 1'b1);
    n_vec++;
    if (a_dout !== 1'b1 || a_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL gap_match: got dout=%b cnt=%0d want dout=1 cnt=1", a_dout, a_cnt);
    end
    step(1'b0, 1'b0);
    n_vec++;
    if (a_dout !== 1'b0) begin
      n_err++;
      $display("FAIL gap_pulse_width: got dout=%b want 0", a_dout);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] pat;
    logic [1:0] exp_cnt;
    pat = 4'b1011;
    overlap = 1'b0;
    clr_cnt = 1'b0;
    idle_start();
    for (int m = 1; m <= 5; m++) begin
      for (int i = 3; i >= 0; i--) begin
        step(1'b1, pat[i]);
        n_vec++;
        if (a_dout !== (i == 0)) begin
          n_err++;
          $display("FAIL sat_dout match %0d bit %0d: got %b want %b", m, 3 - i, a_dout, (i == 0));
        end
      end
      exp_cnt = (m > 3) ? 2'd3 : 2'(m);
      n_vec++;
      if (a_cnt !== exp_cnt) begin
        n_err++;
        $display("FAIL sat_cnt after match %0d: got %0d want %0d", m, a_cnt, exp_cnt);
      end
    end
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    clr_cnt = 1'b1;
    step(1'b1, 1'b1);
    n_vec++;
    if (a_dout !== 1'b1 || a_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL clr_priority: got dout=%b cnt=%0d want dout=1 cnt=0", a_dout, a_cnt);
    end
    clr_cnt = 1'b0;
    step(1'b0, 1'b0);
    n_vec++;
    if (a_dout !== 1'b0 || a_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL clr_after: got dout=%b cnt=%0d want dout=0 cnt=0", a_dout, a_cnt);
    end
  endtask

  task automatic test_reset_mid_match();
    logic [3:0] bits;
    logic [3:0] exp;
    bits = 4'b1011;
    exp  = 4'b0001;
    overlap = 1'b1;
    idle_start();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    n_vec++;
    if (a_pref !== 3'd3) begin
      n_err++;
      $display("FAIL mid_prefix: got %0d want 3", a_pref);
    end
    rst = 1'b1;
    step(1'b1, 1'b1);
    n_vec++;
    if (a_pref !== 3'd0 || a_dout !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got pref=%0d dout=%b want pref=0 dout=0", a_pref, a_dout);
    end
    rst = 1'b0;
    step(1'b1, 1'b1);
    n_vec++;
    if (a_pref !== 3'd0 || a_dout !== 1'b0) begin
      n_err++;
      $display("FAIL mid_idle: got pref=%0d dout=%b want pref=0 dout=0", a_pref, a_dout);
    end
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, bits[i]);
      n_vec++;
      if (a_dout !== exp[i]) begin
        n_err++;
        $display("FAIL mid_stream bit %0d: got %b want %b", 3 - i, a_dout, exp[i]);
      end
    end
    n_vec++;
    if (a_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL mid_cnt: got %0d want 1", a_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_on;
    logic [4:0] exp_off;
    exp_on  = 5'b00111;
    exp_off = 5'b00100;
    overlap = 1'b1;
    idle_start();
    for (int i = 4; i >= 0; i--) begin
      step(1'b1, 1'b1);
      n_vec++;
      if (b_dout !== exp_on[i]) begin
        n_err++;
        $display("FAIL b2b_on_dout bit %0d: got %b want %b", 4 - i, b_dout, exp_on[i]);
      end
    end
    n_vec++;
    if (b_cnt !== 8'd3 || b_pref !== 2'd2) begin
      n_err++;
      $display("FAIL b2b_on_end: got cnt=%0d pref=%0d want cnt=3 pref=2", b_cnt, b_pref);
    end
    overlap = 1'b0;
    idle_start();
    for (int i = 4; i >= 0; i--) begin
      step(1'b1, 1'b1);
      n_vec++;
      if (b_dout !== exp_off[i]) begin
        n_err++;
        $display("FAIL b2b_off_dout bit %0d: got %b want %b", 4 - i, b_dout, exp_off[i]);
      end
    end
    n_vec++;
    if (b_cnt !== 8'd1 || b_pref !== 2'd2) begin
      n_err++;
      $display("FAIL b2b_off_end: got cnt=%0d pref=%0d want cnt=1 pref=2", b_cnt, b_pref);
    end
  endtask

  initial begin
    test_reset();
    test_overlap_on();
    test_overlap_off();
    test_valid_gaps();
    test_saturation();
    test_reset_mid_match();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mealy_seq_detector.md
# mealy_seq_detector

Parametrised Mealy serial pattern detector. It watches a 1-bit qualified input stream for an arbitrary PAT_W-bit pattern and emits a registered one-cycle match pulse. It keeps a saturating match count and supports overlapping and non-overlapping detection, selectable at run time. It sits on serial control and data lines as the general-purpose successor to the team's fixed toggle-on-'1' Mealy detectors.

## Interface
- PAT_W, 4, pattern length in bits (2..16)
- PATTERN, 4'b1011, pattern to detect; PATTERN[PAT_W-1] is the first bit received
- CNT_W, 8, width of the match counter
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- din_valid  in  1  din is sampled only when high
- din  in  1  serial data bit
- overlap  in  1  1 = overlapping matches allowed, 0 = restart after a match
- clr_cnt  in  1  synchronous clear of match_cnt
- dout  out  1  registered Mealy match pulse
- match_cnt  out  CNT_W  number of matches since reset/clear, saturating
- prefix_len  out  $clog2(PAT_W+1)  current matched-prefix length, for debug

## Operation
- States: IDLE, plus P0..P(PAT_W-1). Pk means the last k accepted bits equal the first k pattern bits, with k maximal.
- Reset: state=IDLE, dout=0, match_cnt=0, prefix_len=0.
- IDLE: occupies exactly one clock after rst deasserts. Inputs are ignored, dout=0, and the next state is P0 unconditionally.
- Pk with din_valid=1:
  - Let b=din.
  - If b equals pattern bit k and k<PAT_W-1: go to P(k+1), dout<=0.
  - If b equals pattern bit k and k=PAT_W-1 (match): dout<=1, match_cnt increments.
    - Next state is P(F) if overlap=1, where F is the longest proper prefix of PATTERN that is also a suffix of PATTERN (KMP failure of full length).
    - Next state is P0 if overlap=0, followed by normal P0 processing of the following bits. The matching bit itself is consumed.
  - Mismatch: go to P(j), where j is the longest prefix of the pattern that is a suffix of (matched k bits followed by b). j=0 if none. dout<=0.
- Pk with din_valid=0: state holds, dout<=0, count unchanged.
- overlap is sampled only on a match cycle. A mid-stream change affects the next match only.
- match_cnt saturates at 2^CNT_W-1. When saturated, further matches still pulse dout.
- clr_cnt=1 sets match_cnt<=0 and has priority over a simultaneous increment. dout still pulses on that cycle.
- rst asserted at any time overrides everything. A partial match is discarded, and the IDLE cycle occurs again after release.

## Timing
- Latency: the final pattern bit sampled at edge N gives dout=1 from edge N to edge N+1. Exactly one cycle, never stretched.
- Back-to-back matches (possible only when overlap=1 and F=PAT_W-1, e.g. all-ones pattern) give dout high on consecutive cycles.
- match_cnt updates on the same edge that sets dout.
- prefix_len reflects the registered state. It reads 0 during IDLE.
- No combinational path from inputs to outputs.

## Structure
- Package mealy_seq_detector_pkg holds:
  - the IDLE encoding constant;
  - the state-width function clog2(PAT_W+1)+1, with the MSB as the IDLE flag;
  - the elaboration-time function that builds the next-state table from PATTERN and PAT_W (KMP transition), returning next state per (k, b);
  - the failure-length function F.
- Sub-module sat_counter (parameter W; inputs clr, inc; output cnt) implements match_cnt. It is reused elsewhere.
- The FSM itself is a single clocked process, plus the table lookup.

## Test plan
- Reset/IDLE: hold rst 2 cycles, release, then drive din_valid=1 with bits 1,0,1,1 starting on the first cycle after release. The first '1' falls in IDLE and is ignored, so there is no dout pulse and match_cnt=0.
- Overlap on, PATTERN=1011: after IDLE, stream 1,0,1,1,0,1,1 gives dout pulses after bits 4 and 7, and match_cnt=2.
- Overlap off, same stream: one pulse after bit 4, match_cnt=1, and prefix_len=1 after bit 7.
- Valid gaps: 1,0,(valid=0 for 3 cycles),1,1 gives one pulse after the last bit. prefix_len holds at 2 during the gap.
- Saturation/clear with CNT_W=2: 5 matches give match_cnt=3 and 5 dout pulses. Raising clr_cnt on the cycle of the 6th match gives match_cnt=0 while dout=1.
- Reset mid-match: after 1,0,1, assert rst for 1 cycle, then send 1 (ignored in IDLE), then 1,0,1,1. Exactly one pulse, after the final 1.
